// File: rtl/f11_qdma_arb.sv
// f11_qdma_arb: Q-bus DMA mastership arbiter; stalls the CPU at a bus-cycle boundary and grants one DMR requester.
module f11_qdma_arb #(
   parameter int N_REQ   = 2,
   parameter int GNT_TMO = 64,
   parameter int RR      = 0
) (
   input  logic             pin_clk,
   input  logic             reset,
   input  logic             cpu_sync,
   input  logic             cpu_start,
   input  logic [N_REQ-1:0] dmr,
   input  logic             sack,
   output logic [N_REQ-1:0] dmg,
   output logic             cpu_hold,
   output logic [2:0]       gnt_id,
   output logic             dma_own,
   output logic             tmo,
   output logic             perr
);
   typedef enum logic [2:0] {IDLE, DRAIN, GRANT, MASTER, RELEASE, ORPHAN} state_t;
   state_t state, nxt;
   logic [7:0] cnt;
   logic [2:0] ptr, win_lo, win_hi, win, nxt_gnt;
   logic hi_found, nxt_tmo, nxt_perr;
   logic [N_REQ-1:0] nxt_dmg;
   // descending scan leaves the lowest set index; win_hi only considers indices at or after the pointer
   always_comb begin
      win_lo   = '0;
      win_hi   = '0;
      hi_found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (dmr[i]) win_lo = 3'(i);
         if (dmr[i] && 3'(i) >= ptr) begin
            win_hi   = 3'(i);
            hi_found = 1'b1;
         end
      end
      win = (RR != 0 && hi_found) ? win_hi : win_lo;
   end
   always_comb begin
      nxt      = state;
      nxt_gnt  = gnt_id;
      nxt_tmo  = 1'b0;
      nxt_perr = 1'b0;
      nxt_dmg  = '0;
      case (state)
         IDLE: begin
            if (sack) begin
               nxt      = ORPHAN;
               nxt_perr = 1'b1;
            end else if (|dmr) nxt = DRAIN;
         end
         DRAIN: begin
            if (dmr == '0) nxt = IDLE;
            else if (!cpu_sync && !cpu_start) begin
               nxt     = GRANT;
               nxt_gnt = win;
            end
         end
         GRANT: begin
            // dmg is the one-hot of gnt_id while granting, so it masks the winner's request
            if (sack) nxt = MASTER;
            else if (!(|(dmr & dmg))) nxt = IDLE;
            else if (cnt == 8'(GNT_TMO - 1)) begin
               nxt     = IDLE;
               nxt_tmo = 1'b1;
            end
         end
         MASTER:  nxt = sack ? MASTER : RELEASE;
         RELEASE: nxt = IDLE;
         ORPHAN:  nxt = sack ? ORPHAN : RELEASE;
         default: nxt = IDLE;
      endcase
      for (int i = 0; i < N_REQ; i++) nxt_dmg[i] = (nxt == GRANT) && (nxt_gnt == 3'(i));
   end
   always_ff @(posedge pin_clk) begin
      if (reset) begin
         state    <= IDLE;
         dmg      <= '0;
         cpu_hold <= 1'b0;
         gnt_id   <= '0;
         dma_own  <= 1'b0;
         tmo      <= 1'b0;
         perr     <= 1'b0;
         cnt      <= '0;
         ptr      <= '0;
      end else begin
         state    <= nxt;
         dmg      <= nxt_dmg;
         cpu_hold <= nxt != IDLE;
         gnt_id   <= nxt_gnt;
         dma_own  <= nxt == MASTER;
         tmo      <= nxt_tmo;
         perr     <= nxt_perr;
         cnt      <= (state == GRANT && nxt == GRANT) ? cnt + 8'd1 : '0;
         if (RR != 0 && state == RELEASE) ptr <= (gnt_id >= 3'(N_REQ - 1)) ? 3'd0 : gnt_id + 3'd1;
      end
   end
endmodule

// File: tb/tb_f11_qdma_arb.sv
// tb_f11_qdma_arb: three arbiter configurations against a cycle-level reference model, plus directed literal checks.
module tb_f11_qdma_arb;
   localparam int NI = 3;
   localparam int P_IDLE = 0, P_DRAIN = 1, P_GRANT = 2, P_OWN = 3, P_SETTLE = 4, P_ORPH = 5;
   logic pin_clk = 1'b0, reset = 1'b1, cpu_sync = 1'b0, cpu_start = 1'b0, sack = 1'b0;
   logic [2:0] dmr = 3'd0;
   logic [1:0] dmg0, dmg1;
   logic [2:0] dmg2;
   logic hold [NI], own [NI], tmo_o [NI], perr_o [NI];
   logic [2:0] gnt [NI];
   int errors = 0, checks = 0, cyc = 0;
   bit chk_on = 1'b0;
   int m_ph [NI], m_gid [NI], m_ptr [NI], m_gstart [NI];
   bit m_tmo [NI], m_perr [NI];
   always #5 pin_clk = ~pin_clk;
   f11_qdma_arb #(.N_REQ(2), .GNT_TMO(64), .RR(0)) u0 (.pin_clk(pin_clk), .reset(reset), .cpu_sync(cpu_sync),
      .cpu_start(cpu_start), .dmr(dmr[1:0]), .sack(sack), .dmg(dmg0), .cpu_hold(hold[0]), .gnt_id(gnt[0]),
      .dma_own(own[0]), .tmo(tmo_o[0]), .perr(perr_o[0]));
   f11_qdma_arb #(.N_REQ(2), .GNT_TMO(64), .RR(1)) u1 (.pin_clk(pin_clk), .reset(reset), .cpu_sync(cpu_sync),
      .cpu_start(cpu_start), .dmr(dmr[1:0]), .sack(sack), .dmg(dmg1), .cpu_hold(hold[1]), .gnt_id(gnt[1]),
      .dma_own(own[1]), .tmo(tmo_o[1]), .perr(perr_o[1]));
   f11_qdma_arb #(.N_REQ(3), .GNT_TMO(5), .RR(1)) u2 (.pin_clk(pin_clk), .reset(reset), .cpu_sync(cpu_sync),
      .cpu_start(cpu_start), .dmr(dmr), .sack(sack), .dmg(dmg2), .cpu_hold(hold[2]), .gnt_id(gnt[2]),
      .dma_own(own[2]), .tmo(tmo_o[2]), .perr(perr_o[2]));
   function automatic int n_of(int k);
      return (k == 2) ? 3 : 2;
   endfunction
   function automatic int tmo_of(int k);
      return (k == 2) ? 5 : 64;
   endfunction
   function automatic logic [2:0] dmg_of(int k);
      return (k == 0) ? {1'b0, dmg0} : (k == 1) ? {1'b0, dmg1} : dmg2;
   endfunction
   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[u%0d] t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
      end
   endtask
   function automatic int pick(int k, int req);
      int n = n_of(k);
      int base = (k == 0) ? 0 : m_ptr[k];
      for (int j = 0; j < n; j++)
         if (((req >> ((base + j) % n)) & 1) != 0) return (base + j) % n;
      return 0;
   endfunction
   task automatic model_step(int k);
      int req = int'(dmr) & ((1 << n_of(k)) - 1);
      m_tmo[k] = 1'b0;
      m_perr[k] = 1'b0;
      if (reset) begin
         m_ph[k] = P_IDLE; m_gid[k] = 0; m_ptr[k] = 0;
      end else case (m_ph[k])
         P_IDLE:  if (sack) begin m_ph[k] = P_ORPH; m_perr[k] = 1'b1; end
                  else if (req != 0) m_ph[k] = P_DRAIN;
         P_DRAIN: if (req == 0) m_ph[k] = P_IDLE;
                  else if (!cpu_sync && !cpu_start) begin
                     m_gid[k] = pick(k, req); m_gstart[k] = cyc; m_ph[k] = P_GRANT;
                  end
         P_GRANT: if (sack) m_ph[k] = P_OWN;
                  else if (((req >> m_gid[k]) & 1) == 0) m_ph[k] = P_IDLE;
                  else if (cyc - m_gstart[k] == tmo_of(k)) begin m_ph[k] = P_IDLE; m_tmo[k] = 1'b1; end
         P_OWN:   if (!sack) m_ph[k] = P_SETTLE;
         P_SETTLE: begin
            if (k != 0) m_ptr[k] = (m_gid[k] + 1) % n_of(k);
            m_ph[k] = P_IDLE;
         end
         default: if (!sack) m_ph[k] = P_SETTLE;
      endcase
   endtask
   initial forever begin
      @(posedge pin_clk);
      cyc++;
      for (int k = 0; k < NI; k++) model_step(k);
   end
   initial forever begin
      @(negedge pin_clk);
      if (chk_on)
         for (int k = 0; k < NI; k++) begin
            chk("dmg", k, 32'(dmg_of(k)), (m_ph[k] == P_GRANT) ? 32'(1 << m_gid[k]) : 32'd0);
            chk("cpu_hold", k, 32'(hold[k]), 32'(m_ph[k] != P_IDLE));
            chk("gnt_id", k, 32'(gnt[k]), 32'(m_gid[k]));
            chk("dma_own", k, 32'(own[k]), 32'(m_ph[k] == P_OWN));
            chk("tmo", k, 32'(tmo_o[k]), 32'(m_tmo[k]));
            chk("perr", k, 32'(perr_o[k]), 32'(m_perr[k]));
         end
   end
   task automatic tick();
      @(posedge pin_clk);
      #2;
   endtask
   task automatic do_reset();
      reset = 1'b1; sack = 1'b0; dmr = 3'd0; cpu_sync = 1'b0; cpu_start = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask
   task automatic finish_tenure();
      sack = 1'b1; tick();
      sack = 1'b0; dmr = 3'd0; tick(); tick();
   endtask
   initial begin
      int n;
      tick();
      chk_on = 1'b1;
      do_reset();
      chk("rst_hold", 0, 32'(hold[0]), 32'd0);
      chk("rst_gnt", 1, 32'(gnt[1]), 32'd0);
      dmr = 3'd1;
      tick(); chk("t1_hold", 0, 32'(hold[0]), 32'd1); chk("t1_dmg_early", 0, 32'(dmg0), 32'd0);
      tick(); chk("t1_dmg", 0, 32'(dmg0), 32'd1);
      tick(); sack = 1'b1;
      tick(); chk("t1_dmg_drop", 0, 32'(dmg0), 32'd0); chk("t1_own", 0, 32'(own[0]), 32'd1);
      repeat (4) tick();
      sack = 1'b0; dmr = 3'd0;
      tick(); chk("t1_own_off", 0, 32'(own[0]), 32'd0); chk("t1_settle", 0, 32'(hold[0]), 32'd1);
      tick(); chk("t1_release", 0, 32'(hold[0]), 32'd0);
      cpu_sync = 1'b1; dmr = 3'd2;
      tick(); chk("t2_hold", 0, 32'(hold[0]), 32'd1);
      repeat (4) begin tick(); chk("t2_wait", 0, 32'(dmg0), 32'd0); end
      cpu_sync = 1'b0;
      tick(); chk("t2_dmg", 0, 32'(dmg0), 32'd2); chk("t2_gnt", 0, 32'(gnt[0]), 32'd1);
      finish_tenure();
      do_reset();
      dmr = 3'd3;
      tick(); tick();
      chk("t3_fix1", 0, 32'(gnt[0]), 32'd0); chk("t3_rr1", 1, 32'(gnt[1]), 32'd0);
      sack = 1'b1; tick(); sack = 1'b0; tick(); tick(); tick(); tick();
      chk("t3_fix2", 0, 32'(gnt[0]), 32'd0); chk("t3_rr2", 1, 32'(gnt[1]), 32'd1);
      chk("t3_rr2_dmg", 1, 32'(dmg1), 32'd2); chk("t3_rr3", 2, 32'(gnt[2]), 32'd1);
      finish_tenure();
      do_reset();
      dmr = 3'd1; n = 0;
      tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (dmg0 == 2'd1) n++;
         else break;
      end
      chk("t4_len", 0, 32'(n), 32'd64); chk("t4_tmo", 0, 32'(tmo_o[0]), 32'd1);
      chk("t4_idle", 0, 32'(hold[0]), 32'd0);
      tick(); chk("t4_tmo_pulse", 0, 32'(tmo_o[0]), 32'd0); chk("t4_rereq", 0, 32'(hold[0]), 32'd1);
      tick(); chk("t4_regrant", 0, 32'(dmg0), 32'd1);
      dmr = 3'd0; tick(); tick();
      do_reset();
      sack = 1'b1;
      tick(); chk("t5_perr", 0, 32'(perr_o[0]), 32'd1); chk("t5_hold", 0, 32'(hold[0]), 32'd1);
      tick(); chk("t5_perr_pulse", 0, 32'(perr_o[0]), 32'd0); chk("t5_orphan", 0, 32'(hold[0]), 32'd1);
      sack = 1'b0;
      tick(); chk("t5_settle", 0, 32'(hold[0]), 32'd1);
      tick(); chk("t5_free", 0, 32'(hold[0]), 32'd0);
      dmr = 3'd1; tick(); tick(); sack = 1'b1;
      tick(); chk("t5_master", 0, 32'(own[0]), 32'd1);
      reset = 1'b1;
      tick(); chk("t5_rst_own", 0, 32'(own[0]), 32'd0); chk("t5_rst_hold", 0, 32'(hold[0]), 32'd0);
      reset = 1'b0; sack = 1'b0; dmr = 3'd0;
      tick();
      dmr = 3'd1; cpu_sync = 1'b1;
      tick(); dmr = 3'd0;
      tick(); chk("t6_withdraw", 0, 32'(hold[0]), 32'd0); chk("t6_nodmg", 0, 32'(dmg0), 32'd0);
      cpu_sync = 1'b0; dmr = 3'd1;
      tick(); tick(); chk("t6_dmg", 0, 32'(dmg0), 32'd1);
      dmr = 3'd0;
      tick(); chk("t6_drop", 0, 32'(dmg0), 32'd0); chk("t6_notmo", 0, 32'(tmo_o[0]), 32'd0);
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 4) == 0) dmr = 3'($urandom_range(0, 7));
         cpu_sync = ($urandom_range(0, 3) == 0);
         cpu_start = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 3) == 0) sack = ~sack;
         tick();
      end
      do_reset();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
